// File: rtl/tickgen_pkg.sv
// tickgen_pkg: shared FSM state type and reset divisor for multi_rate_tick_gen.
package tickgen_pkg;
  typedef enum logic [1:0] {SETTLE, IDLE, LOAD} state_t;
  localparam int DIV_INIT_DEF = 50;
endpackage

// File: rtl/tickgen_channel.sv
// tickgen_channel: one rate channel holding divisor, wrapping counter and tick/outclk (outclk only with TICKGEN_SQUARE_EN).
module tickgen_channel
  import tickgen_pkg::*;
#(
  parameter int CNT_W    = 16,
  parameter int DIV_INIT = DIV_INIT_DEF
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             clear,
  input  logic             load,
  input  logic             locked,
  input  logic [CNT_W-1:0] div,
  output logic             tick
`ifdef TICKGEN_SQUARE_EN
  ,
  output logic             outclk
`endif
);
  logic [CNT_W-1:0] div_q;
  logic [CNT_W-1:0] cnt;
  always_ff @(posedge refclk) begin
    if (rst) begin
      div_q <= CNT_W'(DIV_INIT);
      cnt   <= '0;
      tick  <= 1'b0;
    end else begin
      if (load) div_q <= div;
      cnt  <= (clear || cnt >= div_q - 1'b1) ? '0 : cnt + 1'b1;
      tick <= locked && cnt == div_q - 1'b1;
    end
  end
`ifdef TICKGEN_SQUARE_EN
  always_ff @(posedge refclk) begin
    outclk <= rst ? 1'b0 : locked && cnt < (div_q >> 1);
  end
`endif
endmodule

// File: rtl/multi_rate_tick_gen.sv
// multi_rate_tick_gen: N_CH phase-aligned programmable tick generators with settle/lock FSM.
// Define TICKGEN_SQUARE_EN to add the ~50% duty outclk outputs.
module multi_rate_tick_gen
  import tickgen_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int CNT_W       = 16,
  parameter int LOCK_CYCLES = 16,
  parameter int DIV_INIT    = DIV_INIT_DEF,
  localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic             refclk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CH_W-1:0]  cfg_ch,
  input  logic [CNT_W-1:0] cfg_div,
  output logic [N_CH-1:0]  tick,
  output logic             locked
`ifdef TICKGEN_SQUARE_EN
  ,
  output logic [N_CH-1:0]  outclk
`endif
);
  localparam int SC_W = $clog2(LOCK_CYCLES + 1);
  state_t state, next_state;
  logic [SC_W-1:0] settle_cnt;
  logic [CH_W-1:0] ch_q;
  logic [CNT_W-1:0] div_q;
  logic fire, in_range, run, load_all;
  assign fire     = cfg_valid && cfg_ready;
  assign in_range = 32'(cfg_ch) < N_CH;
  assign run      = state == IDLE;
  assign load_all = state == LOAD;
  always_comb begin
    next_state = state;
    next_state = (state == LOAD) ? SETTLE :
                 (state == IDLE) ? ((fire && in_range) ? LOAD : IDLE) :
                 (settle_cnt == SC_W'(LOCK_CYCLES - 1)) ? IDLE : SETTLE;
  end
  // locked/cfg_ready trail the state by one edge; cfg_ready drops on the accepting edge itself
  always_ff @(posedge refclk) begin
    if (rst) begin
      state      <= SETTLE;
      settle_cnt <= '0;
      locked     <= 1'b0;
      cfg_ready  <= 1'b0;
      ch_q       <= '0;
      div_q      <= CNT_W'(1);
    end else begin
      state      <= next_state;
      settle_cnt <= (state == SETTLE) ? settle_cnt + 1'b1 : '0;
      locked     <= run;
      cfg_ready  <= run && !fire;
      if (fire) begin
        ch_q  <= cfg_ch;
        div_q <= (cfg_div > CNT_W'(1)) ? cfg_div : CNT_W'(1);
      end
    end
  end
  // channels are gated by run, the value locked takes on the same edge
  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    tickgen_channel #(.CNT_W(CNT_W), .DIV_INIT(DIV_INIT)) u_ch (
      .refclk(refclk),
      .rst(rst),
      .clear(load_all),
      .load(load_all && ch_q == CH_W'(i)),
      .locked(run),
      .div(div_q),
      .tick(tick[i])
`ifdef TICKGEN_SQUARE_EN
      ,
      .outclk(outclk[i])
`endif
    );
  end
endmodule

// File: tb/tb_multi_rate_tick_gen.sv
// tb_multi_rate_tick_gen: randomized and directed checks against an edge-arithmetic reference model.
module tb_multi_rate_tick_gen;
  localparam int N = 3, W = 16, L = 16, DI = 50;
  logic refclk = 1'b0, rst = 1'b1, cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [W-1:0] cfg_div = '0;
  logic cfg_ready, locked;
  logic [N-1:0] tick;
`ifdef TICKGEN_SQUARE_EN
  logic [N-1:0] outclk;
`endif
  int checks = 0, errors = 0;
  int t = 0, e0 = 0, lock_edge = 1 << 30, p_ch = 0, p_div = 1;
  int m_div [N];
  bit m_locked = 0, m_ready = 0, pend = 0, fired = 0;
  logic [N-1:0] m_tick, m_out;

  multi_rate_tick_gen #(.N_CH(N), .CNT_W(W), .LOCK_CYCLES(L), .DIV_INIT(DI)) dut (
    .refclk(refclk),
    .rst(rst),
    .cfg_valid(cfg_valid),
    .cfg_ready(cfg_ready),
    .cfg_ch(cfg_ch),
    .cfg_div(cfg_div),
    .tick(tick),
    .locked(locked)
`ifdef TICKGEN_SQUARE_EN
    ,
    .outclk(outclk)
`endif
  );

  always #5 refclk = ~refclk;

  // Model: t counts edges, e0 is the edge where all counters were last zeroed,
  // lock_edge is the first edge after which locked reads 1.
  task automatic advance();
    @(posedge refclk);
    t++;
    fired = 0;
    if (rst) begin
      foreach (m_div[i]) m_div[i] = DI;
      e0 = t; lock_edge = t + L + 1; m_locked = 0; m_ready = 0; pend = 0;
    end else begin
      if (pend) begin m_div[p_ch] = p_div; e0 = t; pend = 0; end
      fired = cfg_valid && m_ready;
      m_locked = t >= lock_edge;
      if (fired && cfg_ch < N) begin
        pend = 1; p_ch = cfg_ch; p_div = (cfg_div < 2) ? 1 : int'(cfg_div); lock_edge = t + 2 + L;
      end
      m_ready = m_locked && !fired;
    end
    for (int i = 0; i < N; i++) begin
      m_tick[i] = m_locked && t > e0 && ((t - e0) % m_div[i]) == 0;
      m_out[i]  = m_locked && t > e0 && ((t - 1 - e0) % m_div[i]) < m_div[i] / 2;
    end
    @(negedge refclk);
  endtask

  task automatic write(input int ch, input int div);
    int n = 0;
    cfg_valid = 1; cfg_ch = 2'(ch); cfg_div = W'(div);
    do begin advance(); n++; end while (!fired && n < 100);
    cfg_valid = 0;
    checks++;
    if (!fired) begin errors++; $display("FAIL write_accept ch=%0d got no handshake exp handshake within 100 cycles", ch); end
  endtask

  task automatic test_reset();
    int lk = 0;
    rst = 1;
    for (int c = 0; c < 3; c++) begin
      advance();
      checks++;
      if (tick !== 3'b000 || locked !== 1'b0 || cfg_ready !== 1'b0) begin
        errors++; $display("FAIL reset_outputs got tick=%b locked=%b ready=%b exp 000 0 0", tick, locked, cfg_ready);
      end
    end
    rst = 0;
    for (int c = 0; c < 150; c++) begin
      advance();
      if (lk == 0 && locked === 1'b1) lk = t - e0;
      checks++;
      if (tick !== m_tick || locked !== m_locked || cfg_ready !== m_ready) begin
        errors++; $display("FAIL reset_run t=%0d got %b/%b/%b exp %b/%b/%b", t, tick, locked, cfg_ready, m_tick, m_locked, m_ready);
      end
    end
    checks++;
    if (lk != 17) begin errors++; $display("FAIL lock_edge got %0d exp 17", lk); end
  endtask

  task automatic test_single_update();
    int k, co = 0;
    write(1, 4);
    k = t;
    for (int c = 0; c < 230; c++) begin
      advance();
      if (tick[0] && tick[1]) co++;
      checks++;
      if (tick !== m_tick || locked !== m_locked || cfg_ready !== m_ready) begin
        errors++; $display("FAIL update_run t=%0d got %b/%b/%b exp %b/%b/%b", t, tick, locked, cfg_ready, m_tick, m_locked, m_ready);
      end
      if (t == k + 1) begin
        checks++;
        if (locked !== 1'b0) begin errors++; $display("FAIL update_unlock got %b exp 0", locked); end
      end
      if (t == k + 2 + L) begin
        checks++;
        if (locked !== 1'b1) begin errors++; $display("FAIL update_relock got %b exp 1", locked); end
      end
    end
    checks++;
    if (co != 2) begin errors++; $display("FAIL update_coincide got %0d exp 2", co); end
  endtask

  task automatic test_degenerate();
    write(0, 0);
    for (int c = 0; c < 30; c++) begin
      advance();
      checks++;
      if (tick !== m_tick || locked !== m_locked) begin
        errors++; $display("FAIL degen0_run t=%0d got %b/%b exp %b/%b", t, tick, locked, m_tick, m_locked);
      end
    end
    write(2, 1);
    for (int c = 0; c < 60; c++) begin
      advance();
      checks++;
      if (tick !== m_tick || locked !== m_locked || cfg_ready !== m_ready) begin
        errors++; $display("FAIL degen_run t=%0d got %b/%b/%b exp %b/%b/%b", t, tick, locked, cfg_ready, m_tick, m_locked, m_ready);
      end
      if (locked === 1'b1) begin
        checks++;
        if (tick[0] !== 1'b1 || tick[2] !== 1'b1) begin errors++; $display("FAIL degen_every_cycle got %b exp 1x1", tick); end
      end
    end
  endtask

  task automatic test_out_of_range();
    write(3, 9);
    advance();
    checks++;
    if (cfg_ready !== 1'b1 || locked !== 1'b1) begin
      errors++; $display("FAIL oor_ready got ready=%b locked=%b exp 1 1", cfg_ready, locked);
    end
    for (int c = 0; c < 60; c++) begin
      advance();
      checks++;
      if (tick !== m_tick || locked !== m_locked || cfg_ready !== m_ready) begin
        errors++; $display("FAIL oor_run t=%0d got %b/%b/%b exp %b/%b/%b", t, tick, locked, cfg_ready, m_tick, m_locked, m_ready);
      end
    end
  endtask

  task automatic test_reset_mid_update();
    int n2 = 0;
    write(2, 7);
    repeat (6) advance();
    rst = 1;
    repeat (2) advance();
    rst = 0;
    for (int c = 0; c < 130; c++) begin
      advance();
      if (tick[2]) n2++;
      checks++;
      if (tick !== m_tick || locked !== m_locked || cfg_ready !== m_ready) begin
        errors++; $display("FAIL midrst_run t=%0d got %b/%b/%b exp %b/%b/%b", t, tick, locked, cfg_ready, m_tick, m_locked, m_ready);
      end
    end
    checks++;
    if (n2 != 2) begin errors++; $display("FAIL midrst_div50 got %0d ticks exp 2", n2); end
  endtask

`ifdef TICKGEN_SQUARE_EN
  task automatic test_square();
    int k, hi = 0;
    write(0, 5);
    k = t;
    for (int c = 0; c < 40; c++) begin
      advance();
      if (t >= k + 20 && t < k + 30 && outclk[0]) hi++;
      checks++;
      if (outclk !== m_out || tick !== m_tick) begin
        errors++; $display("FAIL square_run t=%0d got %b/%b exp %b/%b", t, outclk, tick, m_out, m_tick);
      end
      if (locked !== 1'b1) begin
        checks++;
        if (outclk !== 3'b000) begin errors++; $display("FAIL square_unlocked got %b exp 000", outclk); end
      end
    end
    checks++;
    if (hi != 4) begin errors++; $display("FAIL square_duty got %0d high exp 4", hi); end
  endtask
`endif

  task automatic test_random();
    for (int c = 0; c < 1500; c++) begin
      cfg_valid = $urandom_range(0, 3) == 0;
      cfg_ch    = 2'($urandom_range(0, 3));
      cfg_div   = W'($urandom_range(0, 12));
      rst       = $urandom_range(0, 299) == 0;
      advance();
      checks++;
      if (tick !== m_tick || locked !== m_locked || cfg_ready !== m_ready) begin
        errors++; $display("FAIL random_run t=%0d got %b/%b/%b exp %b/%b/%b", t, tick, locked, cfg_ready, m_tick, m_locked, m_ready);
      end
`ifdef TICKGEN_SQUARE_EN
      checks++;
      if (outclk !== m_out) begin errors++; $display("FAIL random_outclk t=%0d got %b exp %b", t, outclk, m_out); end
`endif
    end
    rst = 0; cfg_valid = 0;
  endtask

  initial begin
    test_reset();
    test_single_update();
    test_degenerate();
    test_out_of_range();
    test_reset_mid_update();
`ifdef TICKGEN_SQUARE_EN
    test_square();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/multi_rate_tick_gen.md
MULTI_RATE_TICK_GEN -- requirements
Module: multi_rate_tick_gen

Interface
REQ-001 Parameter N_CH, default 4: number of independent rate channels (1..16).
REQ-002 Parameter CNT_W, default 16: divisor and counter width in bits.
REQ-003 Parameter LOCK_CYCLES, default 16: settle length in refclk cycles (>=1).
REQ-004 Parameter DIV_INIT, default 50: divisor loaded into every channel at reset (1 MHz ticks from 50 MHz).
REQ-005 Derived: CH_W = max(1, clog2(N_CH)).
REQ-006 refclk  in  1  single clock; all logic on its rising edge.
REQ-007 rst  in  1  synchronous, active-high reset.
REQ-008 cfg_valid  in  1  divisor-update request.
REQ-009 cfg_ready  out  1  block can accept an update.
REQ-010 cfg_ch  in  CH_W  target channel index.
REQ-011 cfg_div  in  CNT_W  new divisor D.
REQ-012 tick  out  N_CH  one-cycle rate-enable pulse per channel.
REQ-013 locked  out  1  all channels phase-aligned and outputs valid.
REQ-014 outclk  out  N_CH  ~50% duty divided clock-enable level; present only with TICKGEN_SQUARE_EN.

Function
REQ-015 FSM states: SETTLE, IDLE, LOAD.
- SETTLE: counts LOCK_CYCLES cycles, then goes to IDLE.
- IDLE: on cfg_valid & cfg_ready, goes to LOAD.
- LOAD: always goes to SETTLE after one cycle.
REQ-016 cfg_ready = 1 only in IDLE; locked = 1 only in IDLE; both registered.
REQ-017 Handshake fires on the edge where cfg_valid & cfg_ready; cfg_ch/cfg_div are captured on that edge.
REQ-018 Effective divisor: Deff = 1 when cfg_div is 0 or 1, else Deff = cfg_div.
REQ-019 cfg_ch >= N_CH: the handshake completes, but the FSM stays in IDLE. No divisor change, locked does not drop, counters are undisturbed.
REQ-020 LOAD behaviour: writes Deff to the selected channel and clears ALL channel counters to 0 in the same cycle, which phase-aligns all channels.
REQ-021 Each channel counter runs 0..Deff-1 and wraps to 0 in every state except LOAD.
REQ-022 tick[i] = 1 (registered) in the cycle after counter i equals Deff_i-1, only when locked = 1; otherwise 0.
REQ-023 Update latency: for acceptance at edge k, locked and cfg_ready are 0 from edge k+1. They return to 1 at edge k+2+LOCK_CYCLES.
REQ-024 Because counters run through SETTLE, ticks of channels with commensurate divisors coincide on every common multiple of their divisors, counted from the LOAD clear.
REQ-025 cfg_valid may be held high continuously; one update is accepted per IDLE visit.

Reset
REQ-026 While rst = 1: state = SETTLE, settle count = 0, every counter = 0, every divisor = DIV_INIT, tick = 0, locked = 0, cfg_ready = 0, outclk = 0.
REQ-027 Release: locked rises at the LOCK_CYCLES+1-th rising edge after rst falls.
REQ-028 rst asserted mid-SETTLE or mid-LOAD abandons the update; divisors revert to DIV_INIT.

Configuration
REQ-029 Macro TICKGEN_SQUARE_EN.
- Defined: port outclk exists. outclk[i] = 1 (registered) when counter i < Deff_i/2 (integer division) and locked = 1, else 0. Deff=1 gives constant 0; D=4 gives 2 high, 2 low; D=5 gives 2 high, 3 low.
- Undefined: port outclk and its logic are absent; all other behaviour is identical.

Structure
REQ-030 Package tickgen_pkg: FSM state enum (SETTLE, IDLE, LOAD) and the DIV_INIT default constant.
REQ-031 Sub-module tickgen_channel: one per channel, instantiated N_CH times. It holds the divisor register, counter, tick and outclk logic, with inputs clear, load, div and locked.

Verification (bench: N_CH=3, CNT_W=16, LOCK_CYCLES=16, DIV_INIT=50)
REQ-032 Reset and lock.
- Stimulus: rst high for 3 cycles, then low.
- Response: tick=0, locked=0, cfg_ready=0 during reset; locked=1 at the 17th edge after release; each tick[i] has period 50, all channels coincident.
REQ-033 Single update.
- Stimulus: write cfg_ch=1, cfg_div=4, accepted at edge k.
- Response: locked=0 at k+1; locked=1 at k+18; tick[1] period 4; tick[1] coincides with tick[0] every 100 cycles.
REQ-034 Degenerate divisors.
- Stimulus: write cfg_div=0 to ch0, then cfg_div=1 to ch2.
- Response: tick[0] and tick[2] high on every cycle while locked.
REQ-035 Out-of-range channel.
- Stimulus: write cfg_ch=3.
- Response: cfg_ready high again next cycle; locked stays 1; no tick phase disturbance.
REQ-036 Reset mid-update.
- Stimulus: write ch2 div=7, then assert rst during SETTLE.
- Response: all divisors are 50 after relock.
REQ-037 With TICKGEN_SQUARE_EN, D=5 on ch0.
- Response: outclk[0] repeats 2 high, 3 low.
- Response: outclk = 0 while locked = 0.
